fp_fma_arb: RTL

Round-robin arbiter and sequencer that shares one two-stage `fp_fma` datapath between `N_REQ` floating-point requesters (SIMD lanes or warp slots). It owns the FMA input bus and tracks request tags through the fixed FMA latency. It captures FMA stage outputs into a result buffer, and presents them to the downstream rounding stage with a valid/ready handshake. Credit-based issue keeps the non-stallable FMA from ever losing a result.

---
 rtl/fp_fma_arb_pkg.sv | 29 ++
 rtl/fp_res_fifo.sv | 39 +++
 rtl/fp_fma_arb.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fp_fma_arb_pkg.sv
// fp_fma_arb_pkg: op bit indices, operand widths and result payload layout for the FMA arbiter
package fp_fma_arb_pkg;
    localparam int OP_W = 7;
    localparam int OP_FMADD = 0;
    localparam int OP_FMSUB = 1;
    localparam int OP_FNMADD = 2;
    localparam int OP_FNMSUB = 3;
    localparam int OP_FADD = 4;
    localparam int OP_FSUB = 5;
    localparam int OP_FMUL = 6;
    localparam int DATA_W = 65;
    localparam int CLASS_W = 10;
    localparam int REQ_DATA_W = 3 * DATA_W;
    localparam int REQ_CLASS_W = 3 * CLASS_W;
    localparam int FMA_PAYLOAD_W = 85;
    localparam int PL_DIFF = 0;
    localparam int PL_ZERO = 1;
    localparam int PL_INFS = 2;
    localparam int PL_DBZ = 3;
    localparam int PL_QNAN = 4;
    localparam int PL_SNAN = 5;
    localparam int PL_GRS = 6;
    localparam int PL_RM = 9;
    localparam int PL_FMT = 12;
    localparam int PL_REMA = 14;
    localparam int PL_MANT = 16;
    localparam int PL_EXPO = 70;
    localparam int PL_SIG = 84;
endpackage

// File: rtl/fp_res_fifo.sv
// fp_res_fifo: synchronous result FIFO with occupancy count
//   clock, reset (async active-low); wr_en/wr_data push; rd_en pops the head;
//   rd_data shows the head (zero when empty); count is the occupancy.
module fp_res_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic do_rd;
    assign do_rd = rd_en && count != '0;
    assign rd_data = count != '0 ? mem[rd_ptr] : '0;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr == PTR_W'(DEPTH - 1) ? '0 : wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr == PTR_W'(DEPTH - 1) ? '0 : rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(wr_en) - CNT_W'(do_rd);
        end
    end
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        !(wr_en && !do_rd && count == CNT_W'(DEPTH)));
endmodule

// File: rtl/fp_fma_arb.sv
// fp_fma_arb: round-robin sharing of one fp_fma datapath among N_REQ requesters
//   clock, reset (async active-low)
//   req_*: per-requester request bus, req_ready one-hot accept
//   fma_*: operands/op/fmt/rm driven into fp_fma; fma_o_*: fp_fma stage outputs
//   res_*: buffered results with valid/ready; err: sticky tag-tracking error
//   FP_FMA_ARB_PERF_EN adds saturating perf_issue / perf_stall counters
module fp_fma_arb
    import fp_fma_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int TAG_W = 6,
    parameter int LAT = 2,
    parameter int OBUF_DEPTH = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*OP_W-1:0]      req_op,
    input  logic [N_REQ*2-1:0]         req_fmt,
    input  logic [N_REQ*3-1:0]         req_rm,
    input  logic [N_REQ*TAG_W-1:0]     req_tag,
    input  logic [N_REQ*REQ_DATA_W-1:0]  req_data,
    input  logic [N_REQ*REQ_CLASS_W-1:0] req_class,
    output logic [DATA_W-1:0]          fma_data1,
    output logic [DATA_W-1:0]          fma_data2,
    output logic [DATA_W-1:0]          fma_data3,
    output logic [CLASS_W-1:0]         fma_class1,
    output logic [CLASS_W-1:0]         fma_class2,
    output logic [CLASS_W-1:0]         fma_class3,
    output logic                       fma_op_fmadd,
    output logic                       fma_op_fmsub,
    output logic                       fma_op_fnmadd,
    output logic                       fma_op_fnmsub,
    output logic                       fma_op_fadd,
    output logic                       fma_op_fsub,
    output logic                       fma_op_fmul,
    output logic [1:0]                 fma_fmt,
    output logic [2:0]                 fma_rm,
    input  logic                       fma_o_sig,
    input  logic [13:0]                fma_o_expo,
    input  logic [53:0]                fma_o_mant,
    input  logic [1:0]                 fma_o_rema,
    input  logic [1:0]                 fma_o_fmt,
    input  logic [2:0]                 fma_o_rm,
    input  logic [2:0]                 fma_o_grs,
    input  logic                       fma_o_snan,
    input  logic                       fma_o_qnan,
    input  logic                       fma_o_dbz,
    input  logic                       fma_o_infs,
    input  logic                       fma_o_zero,
    input  logic                       fma_o_diff,
    input  logic                       fma_o_ready,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [FMA_PAYLOAD_W-1:0]   res_data,
    output logic [ID_W-1:0]            res_id,
    output logic [TAG_W-1:0]           res_tag,
    output logic                       err
`ifdef FP_FMA_ARB_PERF_EN
    ,
    output logic [31:0]                perf_issue,
    output logic [31:0]                perf_stall
`endif
);
    localparam int IF_W = $clog2(LAT + 1);
    localparam int FC_W = $clog2(OBUF_DEPTH + 1);
    logic [ID_W-1:0] rr_ptr, gnt_id, idx;
    logic [LAT-1:0] sr_v;
    logic [ID_W-1:0] sr_id [LAT];
    logic [TAG_W-1:0] sr_tag [LAT];
    logic [IF_W-1:0] inflight;
    logic [FC_W-1:0] obuf_count;
    logic [OP_W-1:0] gnt_op, op_out;
    logic credit_ok, grant, push_v, cap_v;
    // Highest priority is rr_ptr+1, so scan from the far end and let nearer hits override.
    always_comb begin
        gnt_id = rr_ptr;
        idx = rr_ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (req_valid[idx]) gnt_id = idx;
        end
    end
    // Credit counts results that already own a slot; a same-cycle pop is deliberately ignored.
    assign inflight = IF_W'($countones(sr_v));
    assign credit_ok = int'(obuf_count) + int'(inflight) < OBUF_DEPTH;
    assign grant = reset && |req_valid && credit_ok;
    assign gnt_op = req_op[gnt_id*OP_W +: OP_W];
    // Non-one-hot ops are accepted but travel as a bubble, dropping the request.
    assign push_v = grant && $onehot(gnt_op);
    assign op_out = push_v ? gnt_op : '0;
    assign req_ready = grant ? N_REQ'(1) << gnt_id : '0;
    assign {fma_op_fmul, fma_op_fsub, fma_op_fadd, fma_op_fnmsub, fma_op_fnmadd, fma_op_fmsub, fma_op_fmadd} = op_out;
    assign {fma_data3, fma_data2, fma_data1} = grant ? req_data[gnt_id*REQ_DATA_W +: REQ_DATA_W] : '0;
    assign {fma_class3, fma_class2, fma_class1} = grant ? req_class[gnt_id*REQ_CLASS_W +: REQ_CLASS_W] : '0;
    assign fma_fmt = grant ? req_fmt[gnt_id*2 +: 2] : '0;
    assign fma_rm = grant ? req_rm[gnt_id*3 +: 3] : '0;
    assign cap_v = sr_v[LAT-1];
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= ID_W'(N_REQ - 1);
            sr_v <= '0;
            err <= 1'b0;
        end else begin
            if (grant) rr_ptr <= gnt_id;
            sr_v <= LAT'({sr_v, push_v});
            if (cap_v != fma_o_ready) err <= 1'b1;
        end
    end
    // Id/tag ride alongside the valid bits and need no reset.
    always_ff @(posedge clock) begin
        sr_id[0] <= gnt_id;
        sr_tag[0] <= req_tag[gnt_id*TAG_W +: TAG_W];
        for (int i = 1; i < LAT; i++) begin
            sr_id[i] <= sr_id[i-1];
            sr_tag[i] <= sr_tag[i-1];
        end
    end
    fp_res_fifo #(
        .WIDTH(FMA_PAYLOAD_W + ID_W + TAG_W),
        .DEPTH(OBUF_DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (cap_v),
        .wr_data({fma_o_sig, fma_o_expo, fma_o_mant, fma_o_rema, fma_o_fmt, fma_o_rm, fma_o_grs,
                  fma_o_snan, fma_o_qnan, fma_o_dbz, fma_o_infs, fma_o_zero, fma_o_diff,
                  sr_id[LAT-1], sr_tag[LAT-1]}),
        .rd_en  (res_valid && res_ready),
        .rd_data({res_data, res_id, res_tag}),
        .count  (obuf_count)
    );
    assign res_valid = obuf_count != '0;
`ifdef FP_FMA_ARB_PERF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_issue <= '0;
            perf_stall <= '0;
        end else begin
            if (grant && perf_issue != '1) perf_issue <= perf_issue + 32'd1;
            if (|req_valid && !credit_ok && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule
